// File: rtl/instruction_fetch.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// instruction_fetch
//   Fetch stage between a 1-cycle-latency instruction memory and a decoder with
//   a valid/ready handshake. One fetch is kept in flight. When the decoder
//   stalls, the in-flight read is dropped and re-issued ("replay"), so no skid
//   buffer is needed. Branches flush the stage. Halt/resume park and restart
//   fetching without losing or skipping any instruction.
//
// Parameters
//   RESET_PC       first address fetched after reset
// Ports
//   clock          single clock, rising edge
//   reset          synchronous, active-high
//   pccounter      registered address presented to instruction memory
//   mem_instr      memory data for the address sampled at the previous edge
//   branch_taken   one-cycle redirect qualifier
//   branch_target  redirect address
//   halt           stop fetching (enter HALTED)
//   resume         restart fetching from the held pc
//   instr_out      instruction to decoder
//   instr_pc       address of instr_out
//   instr_valid    instr_out/instr_pc valid
//   instr_ready    decoder accepts at an edge where instr_valid is high
//   halted         high while in HALTED
// -----------------------------------------------------------------------------
module instruction_fetch #(
   parameter logic [7:0] RESET_PC = 8'h00
) (
   input  logic       clock,
   input  logic       reset,
   output logic [7:0] pccounter,
   input  logic [7:0] mem_instr,
   input  logic       branch_taken,
   input  logic [7:0] branch_target,
   input  logic       halt,
   input  logic       resume,
   output logic [7:0] instr_out,
   output logic [7:0] instr_pc,
   output logic       instr_valid,
   input  logic       instr_ready,
   output logic       halted
);

   localparam logic [0:0] ST_RUN    = 1'b0;
   localparam logic [0:0] ST_HALTED = 1'b1;

   logic [0:0] r_state;
   logic [7:0] r_pc;
   logic       r_req_valid;
   logic [7:0] r_req_pc;
   logic [7:0] r_instr_out;
   logic [7:0] r_instr_pc;
   logic       r_instr_valid;

   logic [0:0] w_state_nxt;
   logic [7:0] w_pc_nxt;
   logic       w_req_valid_nxt;
   logic [7:0] w_req_pc_nxt;
   logic [7:0] w_instr_out_nxt;
   logic [7:0] w_instr_pc_nxt;
   logic       w_instr_valid_nxt;
   logic       w_accept;

   // Output slot can take new data when it is empty or being drained this edge.
   assign w_accept = !r_instr_valid || instr_ready;

   // Next-state logic: branch > halt > resume > normal flow (reset in the flop).
   always_comb begin
      w_state_nxt       = r_state;
      w_pc_nxt          = r_pc;
      w_req_valid_nxt   = r_req_valid;
      w_req_pc_nxt      = r_req_pc;
      w_instr_out_nxt   = r_instr_out;
      w_instr_pc_nxt    = r_instr_pc;
      w_instr_valid_nxt = r_instr_valid;

      if (branch_taken) begin
         // Flush everything, even an instruction the decoder is taking now.
         w_pc_nxt          = branch_target;
         w_req_valid_nxt   = 1'b0;
         w_instr_valid_nxt = 1'b0;
         if (halt) begin
            w_state_nxt = ST_HALTED;
         end else begin
            w_state_nxt = r_state;
         end
      end else begin
         case (r_state)
            ST_RUN: begin
               if (halt) begin
                  // Rewind to the in-flight address so it is refetched on resume.
                  w_state_nxt       = ST_HALTED;
                  w_instr_valid_nxt = 1'b0;
                  w_req_valid_nxt   = 1'b0;
                  if (r_req_valid) begin
                     w_pc_nxt = r_req_pc;
                  end else begin
                     w_pc_nxt = r_pc;
                  end
               end else if (r_req_valid && w_accept) begin
                  w_instr_out_nxt   = mem_instr;
                  w_instr_pc_nxt    = r_req_pc;
                  w_instr_valid_nxt = 1'b1;
                  w_req_valid_nxt   = 1'b1;
                  w_req_pc_nxt      = r_pc;
                  w_pc_nxt          = r_pc + 8'd1;
               end else if (r_req_valid) begin
                  // Decoder stalled: drop the returning data, refetch it later.
                  w_pc_nxt        = r_req_pc;
                  w_req_valid_nxt = 1'b0;
               end else begin
                  w_req_valid_nxt = 1'b1;
                  w_req_pc_nxt    = r_pc;
                  w_pc_nxt        = r_pc + 8'd1;
                  if (r_instr_valid && instr_ready) begin
                     w_instr_valid_nxt = 1'b0;
                  end else begin
                     w_instr_valid_nxt = r_instr_valid;
                  end
               end
            end
            ST_HALTED: begin
               w_instr_valid_nxt = 1'b0;
               w_req_valid_nxt   = 1'b0;
               if (halt) begin
                  w_state_nxt = ST_HALTED;
               end else if (resume) begin
                  w_state_nxt = ST_RUN;
               end else begin
                  w_state_nxt = r_state;
               end
            end
            default: begin
               w_state_nxt       = ST_RUN;
               w_req_valid_nxt   = 1'b0;
               w_instr_valid_nxt = 1'b0;
            end
         endcase
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state       <= ST_RUN;
         r_pc          <= RESET_PC;
         r_req_valid   <= 1'b0;
         r_req_pc      <= 8'h00;
         r_instr_out   <= 8'h00;
         r_instr_pc    <= 8'h00;
         r_instr_valid <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_pc          <= w_pc_nxt;
         r_req_valid   <= w_req_valid_nxt;
         r_req_pc      <= w_req_pc_nxt;
         r_instr_out   <= w_instr_out_nxt;
         r_instr_pc    <= w_instr_pc_nxt;
         r_instr_valid <= w_instr_valid_nxt;
      end
   end

   assign pccounter   = r_pc;
   assign instr_out   = r_instr_out;
   assign instr_pc    = r_instr_pc;
   assign instr_valid = r_instr_valid;
   assign halted      = (r_state == ST_HALTED);

endmodule

// File: tb/tb_instruction_fetch.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_instruction_fetch
//   Directed bench for instruction_fetch. Memory model: mem[a] = a ^ 8'hA5 with
//   one cycle of read latency. Main instance uses RESET_PC = 8'h01; a second
//   instance with RESET_PC = 8'hFE free-runs to show address wrap.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

   logic       clock = 1'b0;
   logic       reset;
   logic       branch_taken;
   logic [7:0] branch_target;
   logic       halt;
   logic       resume;
   logic       instr_ready;

   logic [7:0] pccounter, mem_instr, instr_out, instr_pc;
   logic       instr_valid, halted;

   logic [7:0] w_pccounter, w_mem_instr, w_instr_out, w_instr_pc;
   logic       w_instr_valid, w_halted;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clock = ~clock;

   // Memory models: data for the address presented at the previous edge.
   always @(posedge clock) begin
      mem_instr   <= pccounter ^ 8'hA5;
      w_mem_instr <= w_pccounter ^ 8'hA5;
   end

   instruction_fetch #(.RESET_PC(8'h01)) dut (
      .clock(clock), .reset(reset), .pccounter(pccounter), .mem_instr(mem_instr),
      .branch_taken(branch_taken), .branch_target(branch_target), .halt(halt),
      .resume(resume), .instr_out(instr_out), .instr_pc(instr_pc),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .halted(halted)
   );

   instruction_fetch #(.RESET_PC(8'hFE)) dut_wrap (
      .clock(clock), .reset(reset), .pccounter(w_pccounter), .mem_instr(w_mem_instr),
      .branch_taken(1'b0), .branch_target(8'h00), .halt(1'b0),
      .resume(1'b0), .instr_out(w_instr_out), .instr_pc(w_instr_pc),
      .instr_valid(w_instr_valid), .instr_ready(1'b1), .halted(w_halted)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Expect a valid instruction at address epc with data epc ^ A5.
   task automatic chk_instr(input string tag, input logic v, input logic [7:0] pc,
                            input logic [7:0] dat, input logic [7:0] epc);
      logic [7:0] edat;
      edat = epc ^ 8'hA5;
      chk({tag, ".valid"}, {7'd0, v}, 8'd1);
      chk({tag, ".pc"},    pc,        epc);
      chk({tag, ".data"},  dat,       edat);
   endtask

   task automatic chk_bubble(input string tag);
      chk({tag, ".valid"}, {7'd0, instr_valid}, 8'd0);
   endtask

   task automatic chk_halted(input string tag, input logic [7:0] exp);
      chk({tag, ".halted"}, {7'd0, halted}, exp);
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, ".pccounter"}, pccounter,             8'h01);
      chk({tag, ".valid"},     {7'd0, instr_valid},   8'd0);
      chk({tag, ".instr_pc"},  instr_pc,              8'h00);
      chk({tag, ".instr_out"}, instr_out,             8'h00);
      chk({tag, ".halted"},    {7'd0, halted},        8'd0);
   endtask

   initial begin
      reset         = 1'b1;
      branch_taken  = 1'b0;
      branch_target = 8'h00;
      halt          = 1'b0;
      resume        = 1'b0;
      instr_ready   = 1'b1;

      // Reset state
      cyc();
      cyc();
      chk_reset_state("rst");
      reset = 1'b0;

      // First instruction two edges after release; wrap instance alongside
      cyc();
      chk_bubble("start1");
      cyc();
      chk_instr("start.pc01", instr_valid, instr_pc, instr_out, 8'h01);
      chk_instr("wrap.FE", w_instr_valid, w_instr_pc, w_instr_out, 8'hFE);
      cyc();
      chk_instr("run.pc02", instr_valid, instr_pc, instr_out, 8'h02);
      chk_instr("wrap.FF", w_instr_valid, w_instr_pc, w_instr_out, 8'hFF);
      cyc();
      chk_instr("run.pc03", instr_valid, instr_pc, instr_out, 8'h03);
      chk_instr("wrap.00", w_instr_valid, w_instr_pc, w_instr_out, 8'h00);
      cyc();
      chk_instr("run.pc04", instr_valid, instr_pc, instr_out, 8'h04);
      chk_instr("wrap.01", w_instr_valid, w_instr_pc, w_instr_out, 8'h01);
      cyc();
      chk_instr("run.pc05", instr_valid, instr_pc, instr_out, 8'h05);

      // Decoder stall for three edges: output held, then replay bubble
      instr_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk_instr("stall.hold05", instr_valid, instr_pc, instr_out, 8'h05);
      end
      instr_ready = 1'b1;
      cyc();
      chk_bubble("stall.bubble");
      cyc();
      chk_instr("stall.pc06", instr_valid, instr_pc, instr_out, 8'h06);
      cyc();
      chk_instr("stall.pc07", instr_valid, instr_pc, instr_out, 8'h07);
      cyc();
      chk_instr("run.pc08", instr_valid, instr_pc, instr_out, 8'h08);

      // Branch to 40 while 08 is presented: flush, target valid 2 edges later
      branch_taken  = 1'b1;
      branch_target = 8'h40;
      cyc();
      branch_taken = 1'b0;
      chk_bubble("br.flush");
      chk("br.pccounter", pccounter, 8'h40);
      cyc();
      chk_bubble("br.wait");
      cyc();
      chk_instr("br.pc40", instr_valid, instr_pc, instr_out, 8'h40);
      cyc();
      chk_instr("br.pc41", instr_valid, instr_pc, instr_out, 8'h41);

      // Branch to 0E to walk up to 10 for the halt test
      branch_taken  = 1'b1;
      branch_target = 8'h0E;
      cyc();
      branch_taken = 1'b0;
      cyc();
      cyc();
      chk_instr("br2.pc0E", instr_valid, instr_pc, instr_out, 8'h0E);
      cyc();
      cyc();
      chk_instr("br2.pc10", instr_valid, instr_pc, instr_out, 8'h10);

      // Halt while 10 is taken; pc rewinds to the in-flight address 11
      halt = 1'b1;
      cyc();
      halt = 1'b0;
      chk_halted("halt.enter", 8'd1);
      chk_bubble("halt.enter");
      chk("halt.pccounter", pccounter, 8'h11);
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk_halted("halt.idle", 8'd1);
         chk_bubble("halt.idle");
         chk("halt.idle.pccounter", pccounter, 8'h11);
      end
      resume = 1'b1;
      cyc();
      resume = 1'b0;
      chk_halted("resume", 8'd0);
      chk_bubble("resume");
      cyc();
      chk_bubble("resume.issue");
      cyc();
      chk_instr("resume.pc11", instr_valid, instr_pc, instr_out, 8'h11);
      cyc();
      chk_instr("resume.pc12", instr_valid, instr_pc, instr_out, 8'h12);

      // Reset while an instruction is held by a stalled decoder
      instr_ready = 1'b0;
      cyc();
      chk_instr("rst2.hold12", instr_valid, instr_pc, instr_out, 8'h12);
      reset = 1'b1;
      cyc();
      chk_reset_state("rst2");
      reset       = 1'b0;
      instr_ready = 1'b1;
      cyc();
      chk_bubble("rst2.start1");
      cyc();
      chk_instr("rst2.pc01", instr_valid, instr_pc, instr_out, 8'h01);
      cyc();
      chk_instr("rst2.pc02", instr_valid, instr_pc, instr_out, 8'h02);

      // Branch and halt on the same edge: redirect and park at the target
      branch_taken  = 1'b1;
      branch_target = 8'h20;
      halt          = 1'b1;
      cyc();
      branch_taken = 1'b0;
      halt         = 1'b0;
      chk_halted("brhalt", 8'd1);
      chk_bubble("brhalt");
      chk("brhalt.pccounter", pccounter, 8'h20);
      cyc();
      chk_halted("brhalt.idle", 8'd1);
      chk("brhalt.idle.pccounter", pccounter, 8'h20);
      resume = 1'b1;
      cyc();
      resume = 1'b0;
      chk_halted("brhalt.resume", 8'd0);
      cyc();
      chk_bubble("brhalt.issue");
      cyc();
      chk_instr("brhalt.pc20", instr_valid, instr_pc, instr_out, 8'h20);
      cyc();
      chk_instr("brhalt.pc21", instr_valid, instr_pc, instr_out, 8'h21);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 8'h00, SHALL be the address fetched first after reset.
REQ-002 clock  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-004 pccounter  output  8  registered address to instruction memory, sampled by memory each rising edge.
REQ-005 mem_instr  input  8  memory read data; equals mem[pccounter sampled at previous edge] (1-cycle latency).
REQ-006 branch_taken  input  1  redirect request, single-cycle qualifier for branch_target.
REQ-007 branch_target  input  8  redirect address.
REQ-008 halt  input  1  stop fetching.
REQ-009 resume  input  1  restart fetching from held PC.
REQ-010 instr_out  output  8  instruction delivered to decoder.
REQ-011 instr_pc  output  8  address of instr_out.
REQ-012 instr_valid  output  1  instr_out/instr_pc valid.
REQ-013 instr_ready  input  1  decoder accepts; transfer occurs at an edge where instr_valid && instr_ready.
REQ-014 halted  output  1  high while in HALTED state.

Function
REQ-015 Internal state SHALL be: FSM {RUN, HALTED}, req_valid (a fetch was issued at the previous edge), req_pc (its address).
REQ-016 Issue at an edge SHALL mean: req_valid<=1, req_pc<=pccounter, pccounter<=pccounter+1 (8-bit wrap, 8'hFF -> 8'h00).
REQ-017 accept SHALL be (!instr_valid || instr_ready).
REQ-018 RUN, no branch/halt, req_valid && accept: instr_out<=mem_instr, instr_pc<=req_pc, instr_valid<=1, and issue.
REQ-019 RUN, no branch/halt, req_valid && !accept: outputs held unchanged; mem_instr discarded; replay: pccounter<=req_pc, req_valid<=0.
REQ-020 RUN, no branch/halt, !req_valid: issue; if instr_valid && instr_ready then instr_valid<=0.
REQ-021 Steady state with instr_ready=1 SHALL deliver one instruction per cycle with consecutive instr_pc.
REQ-022 branch_taken (RUN or HALTED) SHALL: pccounter<=branch_target, req_valid<=0, instr_valid<=0 (flush, even if instr_ready); first target instruction valid 2 edges after the branch edge.
REQ-023 halt in RUN SHALL: FSM<=HALTED, instr_valid<=0, req_valid<=0, pccounter<=req_pc if req_valid else pccounter (no instruction lost or skipped).
REQ-024 branch_taken and halt same edge: pccounter<=branch_target, FSM<=HALTED.
REQ-025 HALTED: no issue, pccounter holds (except REQ-022), instr_valid=0, halted=1; resume SHALL return to RUN, first issue at the following edge; halt has priority over resume.
REQ-026 Priority SHALL be reset > branch_taken > halt > resume > normal flow.
REQ-027 instr_out/instr_pc SHALL NOT change while instr_valid && !instr_ready, except by flush or reset.

Reset
REQ-028 On reset: pccounter=RESET_PC, req_valid=0, req_pc=8'h00, instr_out=8'h00, instr_pc=8'h00, instr_valid=0, halted=0, FSM=RUN.
REQ-029 mem_instr during and one cycle after reset SHALL be ignored (memory has no reset).
REQ-030 Reset mid-operation SHALL abandon any held or in-flight instruction; first valid instruction is mem[RESET_PC], 2 edges after reset deassertion.

Verification (memory model mem[a]=a^8'hA5, RESET_PC=8'h01)
REQ-031 Reset then instr_ready=1 -> instr_valid rises 2 edges after reset release with instr_pc=01, instr_out=A4, then pc 02,03,04 consecutive cycles.
REQ-032 instr_ready=0 for 3 cycles while instr_pc=05 -> output held at 05/A0; after ready returns, sequence continues 06,07 with no gap beyond replay bubble and no duplicate or skipped pc.
REQ-033 branch_taken with branch_target=8'h40 while instr_pc=08 -> instr_valid low next cycle, then instr_pc=40, instr_out=E5, then 41.
REQ-034 Free-run from RESET_PC=8'hFE -> instr_pc FE, FF, 00, 01 (wrap).
REQ-035 halt at instr_pc=10, 5 idle cycles, resume -> halted=1 and instr_valid=0 while halted; after resume delivery continues from the first undelivered pc, none lost.
REQ-036 reset asserted while instr_valid=1 and instr_ready=0 -> all outputs at REQ-028 values next edge; restart per REQ-031.
